// File: rtl/QPU_defines.sv
// rtl/QPU_defines.sv - shared QPU widths and write-back arbiter state encoding
package QPU_defines;

  localparam int QPU_XLEN             = 32;
  localparam int QPU_RFIDX_REAL_WIDTH = 5;
  localparam int QPU_QUBIT_NUM        = 8;

  localparam logic WBARB_PRI_LP  = 1'b0;
  localparam logic WBARB_PRI_ALU = 1'b1;

  typedef enum logic {
    PRI_LP  = WBARB_PRI_LP,
    PRI_ALU = WBARB_PRI_ALU
  } wbarb_state_e;

endpackage

// File: rtl/qpu_wbck_outreg.sv
// rtl/qpu_wbck_outreg.sv - valid/data output register for a register-file write port
module qpu_wbck_outreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Data holds its last value when no write is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/qpu_exu_wbck_arb.sv
// rtl/qpu_exu_wbck_arb.sv - CRF write-back arbiter, OITF/MOITF retire sequencer (QPU_WBCK_ANTI_STARVE_EN)
module qpu_exu_wbck_arb
  import QPU_defines::*;
#(
  parameter int XLEN       = QPU_XLEN,
  parameter int RFIDX_W    = QPU_RFIDX_REAL_WIDTH,
  parameter int QUBIT_NUM  = QPU_QUBIT_NUM,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_wbck_i_valid,
  output logic                 alu_wbck_i_ready,
  input  logic [XLEN-1:0]      alu_wbck_i_data,
  input  logic [RFIDX_W-1:0]   alu_wbck_i_rdidx,
  input  logic                 lp_wbck_i_valid,
  output logic                 lp_wbck_i_ready,
  input  logic [XLEN-1:0]      lp_wbck_i_data,
  input  logic [RFIDX_W-1:0]   lp_wbck_i_rdidx,
  input  logic [RFIDX_W-1:0]   oitf_ret_rdidx,
  input  logic                 oitf_ret_rdwen,
  input  logic                 oitf_empty,
  output logic                 oitf_ret_ena,
  input  logic                 mres_i_valid,
  output logic                 mres_i_ready,
  input  logic [QUBIT_NUM-1:0] mres_i_list,
  input  logic                 moitf_empty,
  output logic                 moitf_ret_ena,
  output logic                 crf_wen,
  output logic [XLEN-1:0]      crf_wdata,
  output logic [RFIDX_W-1:0]   crf_widx,
  output logic                 mrf_wen,
  output logic [QUBIT_NUM-1:0] mrf_wdata,
  output logic                 wbck_err
);

  logic alu_pri;
  logic lp_win;
  logic alu_hs;
  logic lp_hs;
  logic lp_bad;
  logic mres_hs;
  logic err_set;
  logic unused_rdwen;

  // Every long-pipe write-back is treated as a register write, so rdwen is informational only.
  assign unused_rdwen = oitf_ret_rdwen;

`ifdef QPU_WBCK_ANTI_STARVE_EN
  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  wbarb_state_e state_q, state_d;
  logic [3:0]   starve_q, starve_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PRI_LP;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // In PRI_LP a cycle with both requesters valid is always an ALU loss.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      PRI_LP: begin
        if (!alu_wbck_i_valid) begin
          starve_d = 4'd0;
        end else if (lp_wbck_i_valid) begin
          if (starve_q == STARVE_LAST) begin
            state_d  = PRI_ALU;
            starve_d = 4'd0;
          end else begin
            starve_d = starve_q + 4'd1;
          end
        end
      end
      PRI_ALU: begin
        if (!alu_wbck_i_valid) begin
          starve_d = 4'd0;
        end
        if (alu_hs) begin
          state_d = PRI_LP;
        end
      end
      default: begin
        state_d  = PRI_LP;
        starve_d = 4'd0;
      end
    endcase
  end

  assign alu_pri = (state_q == PRI_ALU);
`else
  logic unused_starve_max;

  assign unused_starve_max = (STARVE_MAX != 0);
  assign alu_pri           = 1'b0;
`endif

  assign lp_win           = lp_wbck_i_valid & ~(alu_pri & alu_wbck_i_valid);
  assign lp_wbck_i_ready  = ~rst & lp_win;
  assign alu_wbck_i_ready = ~rst & alu_wbck_i_valid & ~lp_win;

  assign alu_hs = alu_wbck_i_valid & alu_wbck_i_ready;
  assign lp_hs  = lp_wbck_i_valid & lp_wbck_i_ready;

  // A mismatched or unexpected long-pipe result is still written but never retires the head.
  assign lp_bad       = oitf_empty | (lp_wbck_i_rdidx != oitf_ret_rdidx);
  assign oitf_ret_ena = lp_hs & ~lp_bad;

  assign mres_i_ready  = ~moitf_empty;
  assign mres_hs       = mres_i_valid & mres_i_ready;
  assign moitf_ret_ena = mres_hs & ~rst;

  assign err_set = (lp_hs & lp_bad) | (mres_i_valid & moitf_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbck_err <= 1'b0;
    end else if (err_set) begin
      wbck_err <= 1'b1;
    end
  end

  qpu_wbck_outreg #(
    .W (RFIDX_W + XLEN)
  ) u_crf_outreg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (alu_hs | lp_hs),
    .in_data   (lp_hs ? {lp_wbck_i_rdidx, lp_wbck_i_data}
                      : {alu_wbck_i_rdidx, alu_wbck_i_data}),
    .out_valid (crf_wen),
    .out_data  ({crf_widx, crf_wdata})
  );

  qpu_wbck_outreg #(
    .W (QUBIT_NUM)
  ) u_mrf_outreg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (mres_hs),
    .in_data   (mres_i_list),
    .out_valid (mrf_wen),
    .out_data  (mrf_wdata)
  );

endmodule

// File: tb/tb_qpu_exu_wbck_arb.sv
// tb/tb_qpu_exu_wbck_arb.sv - self-checking bench for qpu_exu_wbck_arb
module tb_qpu_exu_wbck_arb;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_wbck_i_valid, alu_wbck_i_ready;
  logic [31:0] alu_wbck_i_data;
  logic [4:0]  alu_wbck_i_rdidx;
  logic        lp_wbck_i_valid, lp_wbck_i_ready;
  logic [31:0] lp_wbck_i_data;
  logic [4:0]  lp_wbck_i_rdidx;
  logic [4:0]  oitf_ret_rdidx;
  logic        oitf_ret_rdwen, oitf_empty, oitf_ret_ena;
  logic        mres_i_valid, mres_i_ready;
  logic [7:0]  mres_i_list;
  logic        moitf_empty, moitf_ret_ena;
  logic        crf_wen;
  logic [31:0] crf_wdata;
  logic [4:0]  crf_widx;
  logic        mrf_wen;
  logic [7:0]  mrf_wdata;
  logic        wbck_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  qpu_exu_wbck_arb #(
    .XLEN(32), .RFIDX_W(5), .QUBIT_NUM(8), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .alu_wbck_i_valid(alu_wbck_i_valid), .alu_wbck_i_ready(alu_wbck_i_ready),
    .alu_wbck_i_data(alu_wbck_i_data), .alu_wbck_i_rdidx(alu_wbck_i_rdidx),
    .lp_wbck_i_valid(lp_wbck_i_valid), .lp_wbck_i_ready(lp_wbck_i_ready),
    .lp_wbck_i_data(lp_wbck_i_data), .lp_wbck_i_rdidx(lp_wbck_i_rdidx),
    .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_rdwen(oitf_ret_rdwen),
    .oitf_empty(oitf_empty), .oitf_ret_ena(oitf_ret_ena),
    .mres_i_valid(mres_i_valid), .mres_i_ready(mres_i_ready),
    .mres_i_list(mres_i_list), .moitf_empty(moitf_empty),
    .moitf_ret_ena(moitf_ret_ena),
    .crf_wen(crf_wen), .crf_wdata(crf_wdata), .crf_widx(crf_widx),
    .mrf_wen(mrf_wen), .mrf_wdata(mrf_wdata), .wbck_err(wbck_err)
  );

  typedef struct {
    bit          rst_before;
    logic        av;  logic [31:0] ad; logic [4:0] ai;
    logic        lv;  logic [31:0] ld; logic [4:0] li;
    logic [4:0]  oi;  logic        oe;
    logic        mv;  logic [7:0]  ml; logic       me;
    logic        e_ar, e_lr, e_ret, e_mret, e_mr;
    logic        e_cw; logic [4:0] e_wi; logic [31:0] e_wd;
    logic        e_mw; logic [7:0] e_md; logic e_err;
  } vec_t;

  function automatic vec_t mk(
    bit rb, logic av, logic [31:0] ad, logic [4:0] ai,
    logic lv, logic [31:0] ld, logic [4:0] li, logic [4:0] oi, logic oe,
    logic mv, logic [7:0] ml, logic me,
    logic ear, logic elr, logic eret, logic emret, logic emr,
    logic ecw, logic [4:0] ewi, logic [31:0] ewd,
    logic emw, logic [7:0] emd, logic eerr);
    vec_t v;
    v.rst_before = rb;
    v.av = av; v.ad = ad; v.ai = ai;
    v.lv = lv; v.ld = ld; v.li = li; v.oi = oi; v.oe = oe;
    v.mv = mv; v.ml = ml; v.me = me;
    v.e_ar = ear; v.e_lr = elr; v.e_ret = eret; v.e_mret = emret; v.e_mr = emr;
    v.e_cw = ecw; v.e_wi = ewi; v.e_wd = ewd;
    v.e_mw = emw; v.e_md = emd; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_wbck_i_valid = 0; alu_wbck_i_data = 0; alu_wbck_i_rdidx = 0;
    lp_wbck_i_valid = 0;  lp_wbck_i_data = 0;  lp_wbck_i_rdidx = 0;
    oitf_ret_rdidx = 0; oitf_ret_rdwen = 1; oitf_empty = 1;
    mres_i_valid = 0; mres_i_list = 0; moitf_empty = 1;
  endtask

  // Reference model: ALU is owed a turn once it has lost STARVE_MAX cycles in a row.
  int blocked;
  bit alu_turn;
  bit m_err;

  task automatic model_reset();
    blocked = 0; alu_turn = 0; m_err = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    #3;
    @(posedge clk);
    #1 rst = 0;
    model_reset();
  endtask

  task automatic model_eval(inout vec_t v);
    bit lp_wins;
`ifdef QPU_WBCK_ANTI_STARVE_EN
    lp_wins = v.lv && !(v.av && alu_turn);
`else
    lp_wins = v.lv;
`endif
    v.e_lr   = lp_wins;
    v.e_ar   = v.av && !lp_wins;
    v.e_ret  = lp_wins && !v.oe && (v.li == v.oi);
    v.e_mr   = !v.me;
    v.e_mret = v.mv && !v.me;
    v.e_cw   = v.e_lr || v.e_ar;
    v.e_wi   = lp_wins ? v.li : v.ai;
    v.e_wd   = lp_wins ? v.ld : v.ad;
    v.e_mw   = v.e_mret;
    v.e_md   = v.ml;
    if ((lp_wins && !v.e_ret) || (v.mv && v.me)) m_err = 1;
    v.e_err  = m_err;
`ifdef QPU_WBCK_ANTI_STARVE_EN
    if (!v.av) blocked = 0;
    if (alu_turn) begin
      if (v.e_ar) alu_turn = 0;
    end else if (v.av && v.lv) begin
      blocked++;
      if (blocked == STARVE_MAX) begin
        alu_turn = 1;
        blocked = 0;
      end
    end
`endif
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    if (v.rst_before) do_reset();
    alu_wbck_i_valid = v.av; alu_wbck_i_data = v.ad; alu_wbck_i_rdidx = v.ai;
    lp_wbck_i_valid = v.lv;  lp_wbck_i_data = v.ld;  lp_wbck_i_rdidx = v.li;
    oitf_ret_rdidx = v.oi; oitf_empty = v.oe;
    mres_i_valid = v.mv; mres_i_list = v.ml; moitf_empty = v.me;
    #2;
    chk({tag, " alu_ready"}, 32'(alu_wbck_i_ready), 32'(v.e_ar));
    chk({tag, " lp_ready"}, 32'(lp_wbck_i_ready), 32'(v.e_lr));
    chk({tag, " oitf_ret_ena"}, 32'(oitf_ret_ena), 32'(v.e_ret));
    chk({tag, " moitf_ret_ena"}, 32'(moitf_ret_ena), 32'(v.e_mret));
    chk({tag, " mres_ready"}, 32'(mres_i_ready), 32'(v.e_mr));
    @(posedge clk);
    #1;
    chk({tag, " crf_wen"}, 32'(crf_wen), 32'(v.e_cw));
    if (v.e_cw) begin
      chk({tag, " crf_widx"}, 32'(crf_widx), 32'(v.e_wi));
      chk({tag, " crf_wdata"}, crf_wdata, v.e_wd);
    end
    chk({tag, " mrf_wen"}, 32'(mrf_wen), 32'(v.e_mw));
    if (v.e_mw) chk({tag, " mrf_wdata"}, 32'(mrf_wdata), 32'(v.e_md));
    chk({tag, " wbck_err"}, 32'(wbck_err), 32'(v.e_err));
  endtask

  task automatic starve_seq(input int first_alu, input string tag);
    for (int i = 0; i < 6; i++) begin
      bit aw;
      aw = (i == first_alu);
      run_vec(mk(0, 1, 32'h100 + i, 5'd10, 1, 32'h200 + i, 5'd11, 5'd11, 0,
                 0, 8'h0, 0,
                 aw, !aw, !aw, 0, 1,
                 1, aw ? 5'd10 : 5'd11, aw ? 32'h100 + i : 32'h200 + i,
                 0, 8'h0, 0), $sformatf("%s[%0d]", tag, i));
    end
  endtask

  vec_t table_v[12];
  int first_alu;

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    #2;
    chk("reset crf_wen", 32'(crf_wen), 0);
    chk("reset mrf_wen", 32'(mrf_wen), 0);
    chk("reset wbck_err", 32'(wbck_err), 0);
    chk("reset lp_ready", 32'(lp_wbck_i_ready), 0);
    chk("reset oitf_ret_ena", 32'(oitf_ret_ena), 0);
    do_reset();

    table_v[0]  = mk(0, 1, 32'h1234, 3, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 1,  1, 3, 32'h1234, 0, 0, 0);
    table_v[1]  = mk(0, 0, 0, 0, 1, 32'hABCD, 5, 5, 0, 0, 0, 0,   0, 1, 1, 0, 1,  1, 5, 32'hABCD, 0, 0, 0);
    table_v[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,          0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    table_v[3]  = mk(0, 1, 32'h11, 1, 1, 32'h22, 2, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 32'h22, 0, 0, 0);
    table_v[4]  = mk(0, 1, 32'h77, 9, 0, 0, 0, 0, 1, 1, 8'h02, 0, 1, 0, 0, 1, 1,  1, 9, 32'h77, 1, 8'h02, 0);
    table_v[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h81, 0,      0, 0, 0, 1, 1,  0, 0, 0, 1, 8'h81, 0);
    table_v[6]  = mk(0, 0, 0, 0, 1, 32'h5, 0, 0, 0, 0, 0, 0,      0, 1, 1, 0, 1,  1, 0, 32'h5, 0, 0, 0);
    table_v[7]  = mk(0, 0, 0, 0, 1, 32'hDEAD, 7, 6, 0, 0, 0, 0,   0, 1, 0, 0, 1,  1, 7, 32'hDEAD, 0, 0, 1);
    table_v[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,          0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1);
    table_v[9]  = mk(1, 0, 0, 0, 1, 32'h44, 4, 4, 1, 0, 0, 0,     0, 1, 0, 0, 1,  1, 4, 32'h44, 0, 0, 1);
    table_v[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'hFF, 1,      0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
    table_v[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,          0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) run_vec(table_v[i], $sformatf("tbl[%0d]", i));

`ifdef QPU_WBCK_ANTI_STARVE_EN
    first_alu = STARVE_MAX;
`else
    first_alu = -1;
`endif
    do_reset();
    starve_seq(first_alu, "starve");

    // Build up partial starvation, then reset with writes registered.
    do_reset();
    run_vec(mk(0, 1, 32'h1, 1, 1, 32'h2, 2, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 32'h2, 0, 0, 0), "pre[0]");
    run_vec(mk(0, 1, 32'h1, 1, 1, 32'h3, 2, 2, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 2, 32'h3, 0, 0, 0), "pre[1]");
    lp_wbck_i_valid = 0;
    mres_i_valid = 1; mres_i_list = 8'h5A; moitf_empty = 0;
    @(posedge clk);
    #1;
    chk("midrst crf_wen before", 32'(crf_wen), 1);
    chk("midrst mrf_wen before", 32'(mrf_wen), 1);
    lp_wbck_i_valid = 1; lp_wbck_i_rdidx = 2; oitf_ret_rdidx = 2; oitf_empty = 0;
    #2 rst = 1;
    #1;
    chk("midrst crf_wen", 32'(crf_wen), 0);
    chk("midrst mrf_wen", 32'(mrf_wen), 0);
    chk("midrst alu_ready", 32'(alu_wbck_i_ready), 0);
    chk("midrst lp_ready", 32'(lp_wbck_i_ready), 0);
    chk("midrst oitf_ret_ena", 32'(oitf_ret_ena), 0);
    chk("midrst moitf_ret_ena", 32'(moitf_ret_ena), 0);
    @(posedge clk);
    #1 rst = 0;
    idle_inputs();
    model_reset();
    starve_seq(first_alu, "post_rst");

    do_reset();
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = mk(0, $urandom_range(0, 1), $urandom, 5'($urandom), $urandom_range(0, 1), $urandom,
             5'($urandom), 0, ($urandom_range(0, 9) == 0), $urandom_range(0, 1), 8'($urandom),
             ($urandom_range(0, 4) == 0),
             0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.oi = ($urandom_range(0, 9) == 0) ? 5'($urandom) : v.li;
      if ($urandom_range(0, 99) == 0) begin
        v.rst_before = 1;
        do_reset();
        v.rst_before = 0;
      end
      model_eval(v);
      run_vec(v, $sformatf("rnd[%0d]", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
